// File: rtl/decim2_D4_pkg.sv
// Shared constants and FSM encoding for the decim2_D4 boxcar decimator.
// No logic; DECIM_ROUND_EN (rounding) is consumed by decim2_D4_accum.
package decim2_D4_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MAX_LOG2_D = 6;
    localparam int ACC_W          = DEF_DATA_WIDTH + DEF_MAX_LOG2_D;
    localparam int K_W            = $clog2(DEF_MAX_LOG2_D + 1);

    typedef logic [0:0] state_t;
    localparam state_t ST_EMPTY = 1'b0;
    localparam state_t ST_FULL  = 1'b1;

endpackage

// File: rtl/decim2_D4_accum.sv
// Boxcar accumulator: sums 2^k samples, then rounds or floors and shifts them down to one average.
// Latency: result/group_done are combinational on the group-completing accept; state updates next edge.
// Backpressure: none internally; the caller gates accept_i. Rounding is enabled by `define DECIM_ROUND_EN.
module decim2_D4_accum
    import decim2_D4_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_LOG2_D = DEF_MAX_LOG2_D,
    localparam int AW = DATA_WIDTH + MAX_LOG2_D,
    localparam int KW = $clog2(MAX_LOG2_D + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic [KW-1:0]         log2_d_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  accept_i,
    output logic                  last_o,
    output logic                  group_done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  busy_o
);

    logic signed [AW-1:0]   acc_q, acc_d;
    logic [MAX_LOG2_D-1:0]  cnt_q, cnt_d;
    logic [KW-1:0]          k_q, k_d;
    logic [KW-1:0]          k_in;
    logic [KW-1:0]          k_eff;
    logic [MAX_LOG2_D:0]    dm1;
    logic signed [AW-1:0]   ext;
    logic signed [AW-1:0]   rnd;
    logic signed [AW-1:0]   sum;

    assign k_in  = (log2_d_i > KW'(MAX_LOG2_D)) ? KW'(MAX_LOG2_D) : log2_d_i;
    // The first sample of a group uses the live exponent; later ones use the latched one.
    assign k_eff = (cnt_q == '0) ? k_in : k_q;
    assign dm1   = ((MAX_LOG2_D+1)'(1) << k_eff) - (MAX_LOG2_D+1)'(1);
    assign last_o = ({1'b0, cnt_q} == dm1);

    assign ext = {{MAX_LOG2_D{in_data_i[DATA_WIDTH-1]}}, in_data_i};
`ifdef DECIM_ROUND_EN
    assign rnd = (k_eff == '0) ? '0 : (AW'(1) << (k_eff - KW'(1)));
`else
    assign rnd = '0;
`endif
    assign sum = acc_q + ext + rnd;

    assign result_o     = DATA_WIDTH'(sum >>> k_eff);
    assign group_done_o = accept_i && last_o;
    assign busy_o       = (cnt_q != '0);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        k_d   = k_q;
        if (accept_i) begin
            if (cnt_q == '0) begin
                k_d = k_in;
            end
            if (last_o) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = acc_q + ext;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            acc_q <= '0;
            cnt_q <= '0;
            k_q   <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            k_q   <= k_d;
        end
    end

endmodule

// File: rtl/decim2_d4_boxcar.sv
// Stream decimator by 2^k: emits the average of each group of 2^k signed input samples.
// Latency: out_valid rises one cycle after the group-completing accept; k=0 is 1-cycle passthrough.
// Backpressure: only the group-completing sample stalls while a result is held; rounding with DECIM_ROUND_EN.
module decim2_d4_boxcar
    import decim2_D4_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_LOG2_D = DEF_MAX_LOG2_D
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic [$clog2(MAX_LOG2_D+1)-1:0]    log2_d,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               busy
);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   out_q, out_d;
    logic                    accept;
    logic                    last;
    logic                    group_done;
    logic [DATA_WIDTH-1:0]   result;

    decim2_D4_accum #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_LOG2_D (MAX_LOG2_D)
    ) u_accum (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear),
        .log2_d_i     (log2_d),
        .in_data_i    (in_data),
        .accept_i     (accept),
        .last_o       (last),
        .group_done_o (group_done),
        .result_o     (result),
        .busy_o       (busy)
    );

    assign in_ready = !rst && !clear && !(state_q == ST_FULL && !out_ready && last);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        if (group_done) begin
            state_d = ST_FULL;
            out_d   = result;
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign out_data  = out_q;
    assign out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_decim2_d4_boxcar.sv
// Directed bench for decim2_d4_boxcar; expected averages are hand-computed for both rounding modes.
module tb_decim2_d4_boxcar;

    localparam int DW = 32;
`ifdef DECIM_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 clear = 1'b0;
    logic [2:0]           log2_d = 3'd2;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic                 busy;

    decim2_d4_boxcar dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .log2_d    (log2_d),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [DW-1:0] got_q[$];
    int                   got_cyc[$];
    int                   acc_cyc[$];

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_cyc.push_back(cyc);
        end
        if (in_valid && in_ready) acc_cyc.push_back(cyc);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic signed [DW-1:0] v);
        int n;
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush();
        got_q.delete();
        got_cyc.delete();
        acc_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset state
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // k=2 positive group, latency one cycle after the 4th accept
        flush();
        send(1);
        check("t1_busy", busy, 1);
        send(2); send(3); send(4);
        idle(3);
        check("t1_count", got_q.size(), 1);
        if (got_q.size() == 1) check("t1_value", got_q[0], RND ? 3 : 2);
        if (got_q.size() == 1 && acc_cyc.size() == 4)
            check("t1_latency", got_cyc[0] - acc_cyc[3], 1);
        check("t1_idle_valid", out_valid, 0);

        // k=2 negative group
        flush();
        send(-1); send(-2); send(-3); send(-4);
        idle(3);
        check("t2_count", got_q.size(), 1);
        if (got_q.size() == 1) check("t2_value", got_q[0], RND ? -2 : -3);

        // backpressure: output held, only the 8th sample stalls
        flush();
        out_ready = 1'b0;
        send(10); send(20); send(30); send(40);
        send(1); send(2); send(3);
        in_valid = 1'b1;
        in_data  = 5;
        repeat (3) @(negedge clk);
        check("t3_stall_in_ready", in_ready, 0);
        check("t3_hold_valid", out_valid, 1);
        check("t3_hold_data", out_data, 25);
        check("t3_busy", busy, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        idle(3);
        check("t3_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("t3_first", got_q[0], 25);
            check("t3_second", got_q[1], RND ? 3 : 2);
        end

        // k=0 passthrough
        flush();
        log2_d = 3'd0;
        send(5); send(-7); send(9);
        idle(2);
        check("t4_count", got_q.size(), 3);
        if (got_q.size() == 3 && acc_cyc.size() == 3) begin
            check("t4_v0", got_q[0], 5);
            check("t4_v1", got_q[1], -7);
            check("t4_v2", got_q[2], 9);
            for (int i = 0; i < 3; i++) check("t4_latency", got_cyc[i] - acc_cyc[i], 1);
        end

        // mid-group change of log2_d is ignored until the next boundary
        flush();
        log2_d = 3'd2;
        send(8);
        log2_d = 3'd0;
        send(12); send(16); send(4);
        idle(2);
        check("t4b_count", got_q.size(), 1);
        if (got_q.size() == 1) check("t4b_value", got_q[0], 10);
        flush();
        send(9);
        log2_d = 3'd3;
        repeat (8) send(3);
        idle(2);
        check("t4c_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("t4c_pass", got_q[0], 9);
            check("t4c_avg8", got_q[1], 3);
        end

        // k=6 extremes: no overflow
        flush();
        log2_d = 3'd6;
        repeat (64) send(32'sh7fffffff);
        idle(2);
        check("t5_max_count", got_q.size(), 1);
        if (got_q.size() == 1) check("t5_max", got_q[0], MAXV);
        flush();
        repeat (64) send(32'sh80000000);
        idle(2);
        check("t5_min_count", got_q.size(), 1);
        if (got_q.size() == 1) check("t5_min", got_q[0], MINV);

        // k=3 clear after 5 samples
        flush();
        log2_d = 3'd3;
        repeat (5) send(100);
        check("t6_busy_pre", busy, 1);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 100;
        @(negedge clk);
        check("t6_clear_in_ready", in_ready, 0);
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        check("t6_busy_post", busy, 0);
        check("t6_valid_post", out_valid, 0);
        repeat (8) send(8);
        idle(2);
        check("t6_count", got_q.size(), 1);
        if (got_q.size() == 1) check("t6_value", got_q[0], 8);

        // rst mid-group
        flush();
        repeat (3) send(100);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t7_valid", out_valid, 0);
        check("t7_busy", busy, 0);
        repeat (8) send(1);
        idle(2);
        check("t7_count", got_q.size(), 1);
        if (got_q.size() == 1) check("t7_value", got_q[0], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
